// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller: state encoding, opcodes
// and a helper that identifies states subject to the inactivity timeout.
package atm_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 4'd0,
        ST_PIN     = 4'd1,
        ST_HOME    = 4'd2,
        ST_BALANCE = 4'd3,
        ST_WD_AMT  = 4'd4,
        ST_DEP_AMT = 4'd5,
        ST_XF_ACCT = 4'd6,
        ST_XF_AMT  = 4'd7,
        ST_CONFIRM = 4'd8,
        ST_PRINT   = 4'd9,
        ST_EJECT   = 4'd10,
        ST_RETAIN  = 4'd11
    } atm_state_e;

    localparam logic [2:0] OP_EXIT     = 3'd0;
    localparam logic [2:0] OP_BALANCE  = 3'd1;
    localparam logic [2:0] OP_WITHDRAW = 3'd2;
    localparam logic [2:0] OP_DEPOSIT  = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;

    function automatic logic is_wait_state(input atm_state_e s);
        case (s)
            ST_PIN, ST_HOME, ST_WD_AMT, ST_DEP_AMT,
            ST_XF_ACCT, ST_XF_AMT, ST_CONFIRM: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/atm_timeout_cnt.sv
// Idle-cycle counter: counts while enabled and not cleared, saturates at CYC-1
// and flags expiry while sitting at that value.
module atm_timeout_cnt #(
    parameter int unsigned CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYC - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: restart on clear or outside waiting states, hold at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/atm_session_ctrl.sv
// Single-card ATM session controller: session FSM, balance and PIN-retry
// registers, with registered one-cycle pulse outputs.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned          AMOUNT_W     = 32,
    parameter int unsigned          ACCT_W       = 16,
    parameter int unsigned          PIN_W        = 4,
    parameter int unsigned          MAX_TRIES    = 3,
    parameter int unsigned          TIMEOUT_CYC  = 1024,
    parameter logic [AMOUNT_W-1:0]  INIT_BALANCE = 32'h000186A0,
    parameter logic [PIN_W-1:0]     CARD_PIN     = 4'hE,
    parameter logic [ACCT_W-1:0]    DEST_ACCT    = 16'hD903
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                card_in,
    input  logic                pin_valid,
    input  logic [PIN_W-1:0]    pin,
    input  logic                op_valid,
    input  logic [2:0]          opcode,
    input  logic                amt_valid,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                acct_valid,
    input  logic [ACCT_W-1:0]   dest_acct,
    input  logic                rcpt_valid,
    input  logic                take_receipt,
    output logic [AMOUNT_W-1:0] balance,
    output logic                show_balance,
    output logic                dispense,
    output logic                tx_done,
    output logic                tx_error,
    output logic                print_rcpt,
    output logic                card_eject,
    output logic                card_retain,
    output logic [3:0]          state_o
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] MAX_TRIES_L = TRIES_W'(MAX_TRIES);

    atm_state_e          state_q, state_d, fsm_next_s;
    logic [AMOUNT_W-1:0] balance_q, balance_d;
    logic [TRIES_W-1:0]  tries_q, tries_d, tries_inc_s;
    logic                show_balance_q, show_balance_d;
    logic                dispense_q, dispense_d;
    logic                tx_done_q, tx_done_d;
    logic                tx_error_q, tx_error_d;
    logic                print_rcpt_q, print_rcpt_d;
    logic                card_eject_q, card_eject_d;
    logic                card_retain_q, card_retain_d;
    logic [AMOUNT_W:0]   dep_sum_s;
    logic                any_qual_s, tmo_expired_s, tmo_fire_s, tmo_clear_s;

    assign any_qual_s  = card_in | pin_valid | op_valid | amt_valid | acct_valid | rcpt_valid;
    assign dep_sum_s   = {1'b0, balance_q} + {1'b0, amount};
    assign tries_inc_s = tries_q + TRIES_W'(1);
    // A qualifier in the expiry cycle takes precedence over the timeout.
    assign tmo_fire_s  = tmo_expired_s & ~any_qual_s;
    assign tmo_clear_s = any_qual_s | (state_d != state_q);

    atm_timeout_cnt #(.CYC(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (is_wait_state(state_q)),
        .clear   (tmo_clear_s),
        .expired (tmo_expired_s)
    );

    // Session FSM decisions and balance/tries updates.
    always_comb begin
        fsm_next_s = state_q;
        balance_d  = balance_q;
        tries_d    = tries_q;
        dispense_d = 1'b0;
        tx_done_d  = 1'b0;
        tx_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (card_in) begin
                    fsm_next_s = ST_PIN;
                    tries_d    = {TRIES_W{1'b0}};
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_PIN: begin
                if (!pin_valid) begin
                    fsm_next_s = ST_PIN;
                end else if (pin == CARD_PIN) begin
                    fsm_next_s = ST_HOME;
                end else begin
                    tries_d    = tries_inc_s;
                    fsm_next_s = (tries_inc_s == MAX_TRIES_L) ? ST_RETAIN : ST_PIN;
                end
            end
            ST_HOME: begin
                if (op_valid) begin
                    case (opcode)
                        OP_EXIT:     fsm_next_s = ST_EJECT;
                        OP_BALANCE:  fsm_next_s = ST_BALANCE;
                        OP_WITHDRAW: fsm_next_s = ST_WD_AMT;
                        OP_DEPOSIT:  fsm_next_s = ST_DEP_AMT;
                        OP_TRANSFER: fsm_next_s = ST_XF_ACCT;
                        default:     fsm_next_s = ST_HOME;
                    endcase
                end else begin
                    fsm_next_s = ST_HOME;
                end
            end
            ST_WD_AMT, ST_XF_AMT: begin
                if (!amt_valid) begin
                    fsm_next_s = state_q;
                end else if ((amount == {AMOUNT_W{1'b0}}) || (amount > balance_q)) begin
                    tx_error_d = 1'b1;
                end else begin
                    balance_d  = balance_q - amount;
                    dispense_d = (state_q == ST_WD_AMT);
                    tx_done_d  = 1'b1;
                    fsm_next_s = ST_CONFIRM;
                end
            end
            ST_DEP_AMT: begin
                if (!amt_valid) begin
                    fsm_next_s = ST_DEP_AMT;
                end else if ((amount == {AMOUNT_W{1'b0}}) || dep_sum_s[AMOUNT_W]) begin
                    tx_error_d = 1'b1;
                end else begin
                    balance_d  = dep_sum_s[AMOUNT_W-1:0];
                    tx_done_d  = 1'b1;
                    fsm_next_s = ST_CONFIRM;
                end
            end
            ST_XF_ACCT: begin
                if (!acct_valid) begin
                    fsm_next_s = ST_XF_ACCT;
                end else if (dest_acct == DEST_ACCT) begin
                    fsm_next_s = ST_XF_AMT;
                end else begin
                    tx_error_d = 1'b1;
                end
            end
            ST_CONFIRM: begin
                if (rcpt_valid) begin
                    fsm_next_s = take_receipt ? ST_PRINT : ST_HOME;
                end else begin
                    fsm_next_s = ST_CONFIRM;
                end
            end
            ST_BALANCE, ST_PRINT: fsm_next_s = ST_HOME;
            ST_EJECT, ST_RETAIN:  fsm_next_s = ST_IDLE;
            default:              fsm_next_s = ST_IDLE;
        endcase
    end

    // Final next state and the state-entry pulses (high for the one cycle spent there).
    always_comb begin
        state_d        = tmo_fire_s ? ST_EJECT : fsm_next_s;
        show_balance_d = (state_d == ST_BALANCE);
        print_rcpt_d   = (state_d == ST_PRINT);
        card_eject_d   = (state_d == ST_EJECT);
        card_retain_d  = (state_d == ST_RETAIN);
    end

    // State, balance, tries and output pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            balance_q      <= INIT_BALANCE;
            tries_q        <= {TRIES_W{1'b0}};
            show_balance_q <= 1'b0;
            dispense_q     <= 1'b0;
            tx_done_q      <= 1'b0;
            tx_error_q     <= 1'b0;
            print_rcpt_q   <= 1'b0;
            card_eject_q   <= 1'b0;
            card_retain_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            balance_q      <= balance_d;
            tries_q        <= tries_d;
            show_balance_q <= show_balance_d;
            dispense_q     <= dispense_d;
            tx_done_q      <= tx_done_d;
            tx_error_q     <= tx_error_d;
            print_rcpt_q   <= print_rcpt_d;
            card_eject_q   <= card_eject_d;
            card_retain_q  <= card_retain_d;
        end
    end

    assign balance      = balance_q;
    assign show_balance = show_balance_q;
    assign dispense     = dispense_q;
    assign tx_done      = tx_done_q;
    assign tx_error     = tx_error_q;
    assign print_rcpt   = print_rcpt_q;
    assign card_eject   = card_eject_q;
    assign card_retain  = card_retain_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scenario bench for atm_session_ctrl: expected snapshots are queued as each
// stimulus cycle is driven and compared against the DUT after the edge.
module tb_atm_session_ctrl;

    localparam int unsigned T = 1024;
    localparam logic [31:0] B0 = 32'd100000;

    localparam logic [3:0] S_IDLE = 4'd0, S_PIN = 4'd1, S_HOME = 4'd2, S_BAL = 4'd3,
                           S_WD = 4'd4, S_DEP = 4'd5, S_XFA = 4'd6, S_XFM = 4'd7,
                           S_CONF = 4'd8, S_PRT = 4'd9, S_EJ = 4'd10, S_RET = 4'd11;
    // Pulse order: show, dispense, done, error, print, eject, retain.
    localparam logic [6:0] P_NONE = 7'b0000000, P_SHOW = 7'b1000000, P_DISP = 7'b0100000,
                           P_DONE = 7'b0010000, P_ERR = 7'b0001000, P_PRT = 7'b0000100,
                           P_EJ = 7'b0000010, P_RET = 7'b0000001;
    localparam int K_NONE = 0, K_CARD = 1, K_PIN = 2, K_OP = 3, K_AMT = 4,
                   K_ACCT = 5, K_RCPT = 6, K_RST = 7;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] bal;
        logic [6:0]  pul;
    } snap_t;

    typedef struct {
        int          kind;
        logic [31:0] val;
        snap_t       exp;
    } step_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        card_in = 1'b0, pin_valid = 1'b0, op_valid = 1'b0, amt_valid = 1'b0;
    logic        acct_valid = 1'b0, rcpt_valid = 1'b0, take_receipt = 1'b0;
    logic [3:0]  pin = 4'd0;
    logic [2:0]  opcode = 3'd0;
    logic [31:0] amount = 32'd0;
    logic [15:0] dest_acct = 16'd0;
    logic [31:0] balance;
    logic        show_balance, dispense, tx_done, tx_error, print_rcpt, card_eject, card_retain;
    logic [3:0]  state_o;

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    step_t plan[$];
    snap_t got, e;

    atm_session_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .card_in(card_in), .pin_valid(pin_valid), .pin(pin),
        .op_valid(op_valid), .opcode(opcode), .amt_valid(amt_valid), .amount(amount),
        .acct_valid(acct_valid), .dest_acct(dest_acct), .rcpt_valid(rcpt_valid),
        .take_receipt(take_receipt), .balance(balance), .show_balance(show_balance),
        .dispense(dispense), .tx_done(tx_done), .tx_error(tx_error), .print_rcpt(print_rcpt),
        .card_eject(card_eject), .card_retain(card_retain), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic snap_t sn(input logic [3:0] s, input logic [31:0] b, input logic [6:0] p);
        snap_t r;
        r.st = s; r.bal = b; r.pul = p;
        return r;
    endfunction

    function automatic snap_t obs_now();
        return sn(state_o, balance, {show_balance, dispense, tx_done, tx_error,
                                     print_rcpt, card_eject, card_retain});
    endfunction

    task automatic add(input int k, input logic [31:0] v, input logic [3:0] s,
                       input logic [31:0] b, input logic [6:0] p);
        step_t st;
        st.kind = k; st.val = v; st.exp = sn(s, b, p);
        plan.push_back(st);
    endtask

    task automatic drive_in(input int k, input logic [31:0] v);
        case (k)
            K_CARD: card_in = 1'b1;
            K_PIN:  begin pin_valid = 1'b1; pin = v[3:0]; end
            K_OP:   begin op_valid = 1'b1; opcode = v[2:0]; end
            K_AMT:  begin amt_valid = 1'b1; amount = v; end
            K_ACCT: begin acct_valid = 1'b1; dest_acct = v[15:0]; end
            K_RCPT: begin rcpt_valid = 1'b1; take_receipt = v[0]; end
            K_RST:  reset = 1'b1;
            default: ;
        endcase
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        reset = 1'b0; card_in = 1'b0; pin_valid = 1'b0; op_valid = 1'b0;
        amt_valid = 1'b0; acct_valid = 1'b0; rcpt_valid = 1'b0; take_receipt = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_step();
    endtask

    task automatic test_reset();
        reset = 1'b1; card_in = 1'b1;
        exp_q.push_back(sn(S_IDLE, B0, P_NONE));
        clk_step();
        got = obs_now(); e = exp_q.pop_front(); checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                     got.st, got.bal, got.pul, e.st, e.bal, e.pul);
        end
    endtask

    task automatic test_balance();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        add(K_OP, 32'd1, S_BAL, B0, P_SHOW);
        add(K_NONE, 32'd0, S_HOME, B0, P_NONE);
        add(K_OP, 32'd5, S_HOME, B0, P_NONE);
        add(K_OP, 32'd0, S_EJ, B0, P_EJ);
        add(K_NONE, 32'd0, S_IDLE, B0, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL balance step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_retain();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'h3, S_PIN, B0, P_NONE);
        add(K_NONE, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'h5, S_PIN, B0, P_NONE);
        add(K_PIN, 32'h7, S_RET, B0, P_RET);
        add(K_NONE, 32'd0, S_IDLE, B0, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL retain step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        add(K_AMT, 32'd5, S_HOME, B0, P_NONE);
        add(K_OP, 32'd2, S_WD, B0, P_NONE);
        add(K_AMT, 32'd100001, S_WD, B0, P_ERR);
        add(K_AMT, 32'd0, S_WD, B0, P_ERR);
        add(K_AMT, 32'd40000, S_CONF, 32'd60000, P_DISP | P_DONE);
        add(K_RCPT, 32'd1, S_PRT, 32'd60000, P_PRT);
        add(K_NONE, 32'd0, S_HOME, 32'd60000, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL withdraw step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_transfer();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        add(K_OP, 32'd4, S_XFA, B0, P_NONE);
        add(K_ACCT, 32'hD902, S_XFA, B0, P_ERR);
        add(K_ACCT, 32'hD903, S_XFM, B0, P_NONE);
        add(K_AMT, 32'd100000, S_CONF, 32'd0, P_DONE);
        add(K_RCPT, 32'd0, S_HOME, 32'd0, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL transfer step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_deposit();
        logic [31:0] room;
        room = 32'hFFFF_FFFF - 32'd100005;
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        add(K_OP, 32'd3, S_DEP, B0, P_NONE);
        add(K_AMT, 32'hFFFF_FFFF, S_DEP, B0, P_ERR);
        add(K_AMT, 32'd5, S_CONF, 32'd100005, P_DONE);
        add(K_RCPT, 32'd0, S_HOME, 32'd100005, P_NONE);
        add(K_OP, 32'd3, S_DEP, 32'd100005, P_NONE);
        add(K_AMT, room + 32'd1, S_DEP, 32'd100005, P_ERR);
        add(K_AMT, room, S_CONF, 32'hFFFF_FFFF, P_DONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL deposit step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        for (int k = 0; k < int'(T) - 1; k++) add(K_NONE, 32'd0, S_HOME, B0, P_NONE);
        // Ignored opcode lands on the expiry cycle: it wins and restarts the count.
        add(K_OP, 32'd7, S_HOME, B0, P_NONE);
        for (int k = 0; k < int'(T) - 1; k++) add(K_NONE, 32'd0, S_HOME, B0, P_NONE);
        add(K_NONE, 32'd0, S_EJ, B0, P_EJ);
        add(K_NONE, 32'd0, S_IDLE, B0, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL timeout step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    task automatic test_midsession_reset();
        do_reset(); plan.delete();
        add(K_CARD, 32'd0, S_PIN, B0, P_NONE);
        add(K_PIN, 32'hE, S_HOME, B0, P_NONE);
        add(K_OP, 32'd3, S_DEP, B0, P_NONE);
        add(K_AMT, 32'd5, S_CONF, 32'd100005, P_DONE);
        add(K_RCPT, 32'd0, S_HOME, 32'd100005, P_NONE);
        add(K_OP, 32'd2, S_WD, 32'd100005, P_NONE);
        add(K_RST, 32'd0, S_IDLE, B0, P_NONE);
        add(K_NONE, 32'd0, S_IDLE, B0, P_NONE);
        foreach (plan[i]) begin
            drive_in(plan[i].kind, plan[i].val);
            exp_q.push_back(plan[i].exp);
            clk_step();
            got = obs_now(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL midreset step %0d: got st=%0d bal=%0d pul=%b, expected st=%0d bal=%0d pul=%b",
                         i, got.st, got.bal, got.pul, e.st, e.bal, e.pul);
            end
        end
    endtask

    initial begin
        test_reset();
        test_balance();
        test_retain();
        test_withdraw();
        test_transfer();
        test_deposit();
        test_timeout();
        test_midsession_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller: one FSM plus balance register for a single card session. It covers card insertion, PIN entry with a registered retry limit and card retention, withdraw, deposit, transfer, balance display, receipt printing, and an inactivity timeout. It sits between the keypad/card-reader front end and the dispenser/printer/display drivers. Every input is a valid-qualified pulse; outputs are registered.

## Interface
Parameters:
- AMOUNT_W, 32, width of balance and amounts
- ACCT_W, 16, account number width
- PIN_W, 4, PIN width
- MAX_TRIES, 3, wrong PINs before the card is retained (≥1)
- TIMEOUT_CYC, 1024, idle cycles in any waiting state before the session aborts
- INIT_BALANCE, 32'h000186A0, balance after reset
- CARD_PIN, 4'hE, correct PIN
- DEST_ACCT, 16'hD903, only valid transfer destination

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, synchronous reset active-high
- card_in  in  1  card inserted pulse
- pin_valid  in  1  pin qualifier
- pin  in  PIN_W  entered PIN
- op_valid  in  1  opcode qualifier
- opcode  in  3  0 exit, 1 balance, 2 withdraw, 3 deposit, 4 transfer, 5–7 ignored
- amt_valid  in  1  amount qualifier
- amount  in  AMOUNT_W  transaction amount
- acct_valid  in  1  account qualifier
- dest_acct  in  ACCT_W  transfer destination
- rcpt_valid  in  1  receipt-choice qualifier
- take_receipt  in  1  1 = print
- balance  out  AMOUNT_W  current balance
- show_balance  out  1  one-cycle pulse
- dispense  out  1  one-cycle pulse (withdraw committed)
- tx_done  out  1  one-cycle pulse on any committed transaction
- tx_error  out  1  one-cycle pulse on rejected request
- print_rcpt  out  1  one-cycle pulse
- card_eject  out  1  one-cycle pulse
- card_retain  out  1  one-cycle pulse
- state_o  out  4  current state code

## Operation
- States: IDLE, PIN, HOME, BALANCE, WD_AMT, DEP_AMT, XF_ACCT, XF_AMT, CONFIRM, PRINT, EJECT, RETAIN.
- IDLE: card_in → PIN; tries cleared.
- PIN: pin_valid with correct PIN → HOME. Wrong PIN increments tries; the transition that reaches MAX_TRIES → RETAIN, otherwise stay in PIN. Tries is a register, updated only on pin_valid.
- HOME: op_valid: 0→EJECT, 1→BALANCE, 2→WD_AMT, 3→DEP_AMT, 4→XF_ACCT; 5–7 stay in HOME with no output.
- BALANCE: pulse show_balance, → HOME.
- WD_AMT: on amt_valid, amount==0 or amount>balance → tx_error, stay. Otherwise balance−=amount, dispense+tx_done, → CONFIRM.
- DEP_AMT: on amt_valid, amount==0 or balance+amount overflows AMOUNT_W → tx_error, stay. Otherwise balance+=amount, tx_done, → CONFIRM. The overflow check uses an AMOUNT_W+1 sum.
- XF_ACCT: acct_valid with dest_acct≠DEST_ACCT → tx_error, stay. Match → XF_AMT.
- XF_AMT: same rules as withdraw, but no dispense; commit → CONFIRM.
- CONFIRM: rcpt_valid: take_receipt=1 → PRINT, 0 → HOME.
- PRINT: pulse print_rcpt, → HOME.
- EJECT: pulse card_eject, → IDLE. RETAIN: pulse card_retain, → IDLE.
- Timeout: in PIN, HOME, WD_AMT, DEP_AMT, XF_ACCT, XF_AMT and CONFIRM, a counter counts cycles with no qualifier asserted. At TIMEOUT_CYC → EJECT. Any qualifier or state change clears the counter.
- Qualifiers not relevant to the current state are ignored. Balance changes only on a committed transaction.

## Timing
- Reset: state IDLE, balance=INIT_BALANCE, tries=0, timeout counter 0. All pulse outputs 0, state_o=0.
- Every decision takes one cycle. The qualifier is sampled at edge N; the new state, balance and pulses are visible after edge N. Each pulse is high for exactly one cycle.
- The timeout fires on the edge where the counter reaches TIMEOUT_CYC−1 with no qualifier present. A qualifier on that same cycle wins over the timeout.
- Reset mid-session aborts without card_eject and restores INIT_BALANCE.

## Structure
- Shared package atm_pkg holds the state enum, the opcode localparams, and the state_o encoding (IDLE=0 … RETAIN=11).
- One sub-module: atm_timeout_cnt, a parametrised counter with clear and expiry.
- FSM, balance and tries registers live in the top level.

## Test plan
- Reset, card_in, pin=E, op=1 → show_balance pulse, balance=100000, state HOME.
- Wrong PINs 3,5,7 → card_retain after third, state IDLE, no HOME visit.
- Withdraw 100001 → tx_error, balance unchanged. Then withdraw 40000 → dispense, balance=60000, take_receipt=1 → print_rcpt.
- Transfer to D902 → tx_error. Then D903 with 100000 → tx_done, balance=0.
- Deposit 32'hFFFFFFFF on balance 100000 → tx_error. Deposit 5 → balance=100005.
- No input for TIMEOUT_CYC cycles in HOME → card_eject, IDLE. Reset asserted in WD_AMT → IDLE, balance=100000.
